// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Holds the tag/valid store internally and drives an external single-port
// data array. arr_data_out is expected one cycle after arr_read_enable, so the
// lookup waits one cycle for the data. Hit/miss decisions are therefore made
// on the second LOOKUP cycle, and a read hit responds two edges after the
// handshake.
//
// Optional feature: define CACHE_STATS_EN to build saturating hit/miss
// counters. Without it, hit_count and miss_count are tied to zero.
//
// Ports:
//   clk, gen_reset              clock, asynchronous active-high reset
//   cpu_req_*                   CPU request (valid/ready, we, word addr, wdata)
//   cpu_resp_valid/rdata        CPU response (rdata is zero for writes)
//   mem_req_*                   memory request (valid/ready, we, addr, wdata)
//   mem_resp_valid/rdata        memory read data or write acknowledge
//   arr_*                       data array control, address and data
//   hit_count, miss_count       lookup statistics
module cache_controller #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned INDEX_BITS = 10,
  parameter int unsigned LINE_BITS  = 64
) (
  input  logic                  clk,
  input  logic                  gen_reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_BITS-1:0]  cpu_req_addr,
  input  logic [LINE_BITS-1:0]  cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [LINE_BITS-1:0]  cpu_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_BITS-1:0]  mem_req_addr,
  output logic [LINE_BITS-1:0]  mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [LINE_BITS-1:0]  mem_resp_rdata,
  output logic                  arr_write_enable,
  output logic                  arr_read_enable,
  output logic [INDEX_BITS-1:0] arr_adress,
  output logic [LINE_BITS-1:0]  arr_data_in,
  input  logic [LINE_BITS-1:0]  arr_data_out,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int unsigned ENTRIES  = 2 ** INDEX_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP} state_t;

  state_t                state;
  logic                  lookup_data_ready;
  logic                  req_we;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [LINE_BITS-1:0]  req_wdata;
  logic [ENTRIES-1:0]    valid_bits;
  logic [TAG_BITS-1:0]   tag_mem [ENTRIES];

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  lookup_hit;
  logic                  lookup_done;
  logic                  tag_fill;

  assign req_index   = req_addr[INDEX_BITS-1:0];
  assign req_tag     = req_addr[ADDR_BITS-1:INDEX_BITS];
  assign lookup_hit  = valid_bits[req_index] && (tag_mem[req_index] == req_tag);
  // Second LOOKUP cycle: array data is valid and the decision is taken.
  assign lookup_done = (state == LOOKUP) && lookup_data_ready;
  // Only a read refill allocates a line.
  assign tag_fill    = (state == MEM_WAIT) && mem_resp_valid && !req_we;

  // Tag storage; validity is tracked separately so reset can clear it.
  always_ff @(posedge clk) begin
    if (tag_fill) tag_mem[req_index] <= req_tag;
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state             <= IDLE;
      lookup_data_ready <= 1'b0;
      req_we            <= 1'b0;
      req_addr          <= '0;
      req_wdata         <= '0;
      valid_bits        <= '0;
      cpu_req_ready     <= 1'b1;
      cpu_resp_valid    <= 1'b0;
      cpu_resp_rdata    <= '0;
      mem_req_valid     <= 1'b0;
      mem_req_we        <= 1'b0;
      mem_req_addr      <= '0;
      mem_req_wdata     <= '0;
      arr_write_enable  <= 1'b0;
      arr_read_enable   <= 1'b0;
      arr_adress        <= '0;
      arr_data_in       <= '0;
    end else begin
      arr_read_enable  <= 1'b0;
      arr_write_enable <= 1'b0;
      cpu_resp_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            req_we            <= cpu_req_we;
            req_addr          <= cpu_req_addr;
            req_wdata         <= cpu_req_wdata;
            arr_read_enable   <= 1'b1;
            arr_adress        <= cpu_req_addr[INDEX_BITS-1:0];
            cpu_req_ready     <= 1'b0;
            lookup_data_ready <= 1'b0;
            state             <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_done) begin
            lookup_data_ready <= 1'b0;
            if (lookup_hit && !req_we) begin
              cpu_resp_valid <= 1'b1;
              cpu_resp_rdata <= arr_data_out;
              state          <= RESP;
            end else begin
              // Write hits update the line now and still write through.
              if (lookup_hit) begin
                arr_write_enable <= 1'b1;
                arr_data_in      <= req_wdata;
              end
              mem_req_valid <= 1'b1;
              mem_req_we    <= req_we;
              mem_req_addr  <= req_addr;
              mem_req_wdata <= req_we ? req_wdata : '0;
              state         <= MEM_REQ;
            end
          end else begin
            lookup_data_ready <= 1'b1;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            if (tag_fill) begin
              arr_write_enable      <= 1'b1;
              arr_data_in           <= mem_resp_rdata;
              valid_bits[req_index] <= 1'b1;
              cpu_resp_rdata        <= mem_resp_rdata;
            end else begin
              cpu_resp_rdata <= '0;
            end
            cpu_resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating lookup statistics.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup_done) begin
      if (lookup_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller. The reference treats the cache as
// transparent over an ideal memory: every read returns the latest value
// written to that address. A per-index record of the resident address decides
// hit/miss, and from that the expected memory traffic, array writes and
// statistics follow.
module tb_cache_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 10;
  localparam int unsigned LW = 64;

  logic          clk;
  logic          gen_reset;
  logic          cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [AW-1:0] cpu_req_addr;
  logic [LW-1:0] cpu_req_wdata;
  logic          cpu_resp_valid;
  logic [LW-1:0] cpu_resp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_rdata;
  logic          arr_write_enable, arr_read_enable;
  logic [IW-1:0] arr_adress;
  logic [LW-1:0] arr_data_in, arr_data_out;
  logic [31:0]   hit_count, miss_count;

  cache_controller #(.ADDR_BITS(AW), .INDEX_BITS(IW), .LINE_BITS(LW)) dut (
    .clk(clk), .gen_reset(gen_reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .arr_write_enable(arr_write_enable), .arr_read_enable(arr_read_enable),
    .arr_adress(arr_adress), .arr_data_in(arr_data_in), .arr_data_out(arr_data_out),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Synchronous-read data array.
  logic [LW-1:0] arr_mem [1024];
  always @(posedge clk) begin
    if (arr_write_enable) arr_mem[arr_adress] <= arr_data_in;
    if (arr_read_enable)  arr_data_out <= arr_mem[arr_adress];
  end

  // Backing memory device and the ideal-memory reference.
  logic [63:0] bmem    [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];

  function automatic logic [63:0] mem_default(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  function automatic logic [63:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_default(a);
  endfunction

  // Memory responder: stalls ready, then answers after a programmable delay.
  int          cfg_stall = 0;
  int          cfg_dly   = 0;
  bit          spur_en   = 1'b0;
  bit          mem_phase = 1'b0;
  int          wait_cnt  = 0;
  int          dly_left  = 0;
  int          macc      = 0;
  logic        macc_we;
  logic [31:0] macc_addr;
  logic [63:0] macc_wdata;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      if (!mem_phase) begin
        if (mem_req_valid && wait_cnt >= cfg_stall) begin
          mem_req_ready = 1'b1;
          macc++;
          macc_we    = mem_req_we;
          macc_addr  = mem_req_addr;
          macc_wdata = mem_req_wdata;
          dly_left   = cfg_dly;
          wait_cnt   = 0;
          mem_phase  = 1'b1;
        end else begin
          wait_cnt = mem_req_valid ? wait_cnt + 1 : 0;
          if (spur_en && $urandom_range(0, 3) == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = {$urandom, $urandom};
          end
        end
      end else if (dly_left > 0) begin
        dly_left--;
      end else begin
        mem_resp_valid = 1'b1;
        if (macc_we) begin
          mem_resp_rdata  = {$urandom, $urandom};
          bmem[macc_addr] = macc_wdata;
        end else begin
          mem_resp_rdata = bmem.exists(macc_addr) ? bmem[macc_addr] : mem_default(macc_addr);
        end
        mem_phase = 1'b0;
      end
    end
  end

  // Interface monitor.
  int          m_mreq = 0, m_aw = 0, m_ar = 0, m_resp = 0, overlap = 0, stab_err = 0;
  logic [9:0]  m_aw_idx;
  logic [63:0] m_aw_data;
  bit          mr_seen = 1'b0;
  logic [31:0] mr_addr;
  logic        mr_we;
  logic [63:0] mr_wd;

  always @(negedge clk) begin
    if (arr_read_enable && arr_write_enable) overlap++;
    if (arr_read_enable) m_ar++;
    if (arr_write_enable) begin
      m_aw++;
      m_aw_idx  = arr_adress;
      m_aw_data = arr_data_in;
    end
    if (cpu_resp_valid) m_resp++;
    if (mem_req_valid) begin
      m_mreq++;
      if (mr_seen && (mr_addr !== mem_req_addr || mr_we !== mem_req_we || mr_wd !== mem_req_wdata))
        stab_err++;
      mr_seen = 1'b1;
      mr_addr = mem_req_addr;
      mr_we   = mem_req_we;
      mr_wd   = mem_req_wdata;
    end else begin
      mr_seen = 1'b0;
    end
  end

  // Reference cache state.
  bit          md_valid [1024];
  logic [31:0] md_addr  [1024];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] stat_exp(input int v);
`ifdef CACHE_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) md_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (cpu_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                         input int stall, input int rdly);
    int          idx;
    bit          exp_hit, exp_mem, exp_aw, got;
    logic [63:0] exp_data, rdata;
    int          b_mreq, b_aw, b_ar, b_resp, b_macc, n;
    idx      = int'(addr[9:0]);
    exp_hit  = md_valid[idx] && (md_addr[idx] == addr);
    exp_data = we ? 64'd0 : ref_read(addr);
    exp_mem  = we || !exp_hit;
    exp_aw   = we ? exp_hit : !exp_hit;
    cfg_stall = stall;
    cfg_dly   = rdly;
    wait_ready();
    b_mreq = m_mreq; b_aw = m_aw; b_ar = m_ar; b_resp = m_resp; b_macc = macc;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (cpu_resp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    rdata = cpu_resp_rdata;
    @(negedge clk); #1;
    check("resp_one_cycle", 64'(cpu_resp_valid), 64'd0);
    check("rdata", rdata, exp_data);
    if (!we && exp_hit) check("hit_latency", 64'(n - 1), 64'd2);
    check("arr_reads", 64'(m_ar - b_ar), 64'd1);
    check("resp_count", 64'(m_resp - b_resp), 64'd1);
    check("mem_accesses", 64'(macc - b_macc), 64'(exp_mem));
    if (exp_mem) begin
      check("mem_we", 64'(macc_we), 64'(we));
      check("mem_addr", 64'(macc_addr), 64'(addr));
      if (we) check("mem_wdata", macc_wdata, wdata);
      check("mem_valid_cycles", 64'(m_mreq - b_mreq), 64'(stall + 1));
    end else begin
      check("mem_valid_cycles", 64'(m_mreq - b_mreq), 64'd0);
    end
    check("arr_writes", 64'(m_aw - b_aw), 64'(exp_aw));
    if (exp_aw) begin
      check("arr_w_index", 64'(m_aw_idx), 64'(idx));
      check("arr_w_data", m_aw_data, we ? wdata : exp_data);
    end
    if (exp_hit) exp_hits++; else exp_misses++;
    if (!we && !exp_hit) begin
      md_valid[idx] = 1'b1;
      md_addr[idx]  = addr;
    end
    if (we) ref_mem[addr] = wdata;
    check("hit_count", 64'(hit_count), 64'(stat_exp(exp_hits)));
    check("miss_count", 64'(miss_count), 64'(stat_exp(exp_misses)));
  endtask

  // Read request aborted by reset in MEM_WAIT (in_wait=1) or MEM_REQ (in_wait=0).
  task automatic abort_req(input bit in_wait, input logic [31:0] addr);
    bit reached = 1'b0;
    int b_resp;
    cfg_stall = in_wait ? 0 : 40;
    cfg_dly   = in_wait ? 15 : 0;
    wait_ready();
    b_resp = m_resp;
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = addr;
    cpu_req_wdata = '0;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (in_wait ? mem_phase : mem_req_valid) begin reached = 1'b1; break; end
    end
    check(in_wait ? "reach_mem_wait" : "reach_mem_req", 64'(reached), 64'd1);
    @(posedge clk); #2;
    check("pre_reset_mem_valid", 64'(mem_req_valid), 64'(!in_wait));
    gen_reset = 1'b1;
    #1;
    check("abort_ready", 64'(cpu_req_ready), 64'd1);
    check("abort_mem_valid", 64'(mem_req_valid), 64'd0);
    check("abort_resp_valid", 64'(cpu_resp_valid), 64'd0);
    @(negedge clk);
    gen_reset = 1'b0;
    model_reset();
    repeat (25) @(negedge clk);
    #1;
    check("abort_no_resp", 64'(m_resp - b_resp), 64'd0);
    for (int i = 0; i < 40 && mem_phase; i++) begin
      @(negedge clk); #1;
    end
    check("mem_idle_after_abort", 64'(mem_phase), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    gen_reset     = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    bmem[32'h5]      = 64'hDEAD_BEEF_0000_0001;
    ref_mem[32'h5]   = 64'hDEAD_BEEF_0000_0001;
    bmem[32'h405]    = 64'h0000_0000_0000_00AA;
    ref_mem[32'h405] = 64'h0000_0000_0000_00AA;
    model_reset();

    @(negedge clk); #1;
    check("rst_ready", 64'(cpu_req_ready), 64'd1);
    check("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
    check("rst_resp_rdata", cpu_resp_rdata, 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_req_addr), 64'd0);
    check("rst_arr_we", 64'(arr_write_enable), 64'd0);
    check("rst_arr_re", 64'(arr_read_enable), 64'd0);
    check("rst_arr_adress", 64'(arr_adress), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
    @(negedge clk);
    gen_reset = 1'b0;

    run_req(1'b0, 32'h5,   64'd0,      0, 1);
    run_req(1'b0, 32'h5,   64'd0,      0, 0);
    run_req(1'b1, 32'h5,   64'h1234,   0, 0);
    run_req(1'b0, 32'h5,   64'd0,      0, 0);
    run_req(1'b0, 32'h405, 64'd0,      1, 2);
    run_req(1'b0, 32'h5,   64'd0,      0, 0);
    run_req(1'b1, 32'h7FF, 64'hCAFE_F00D, 3, 1);
    run_req(1'b0, 32'h7FF, 64'd0,      0, 0);

    spur_en = 1'b1;
    abort_req(1'b1, 32'h805);
    run_req(1'b0, 32'h5, 64'd0, 0, 0);
    abort_req(1'b0, 32'h123);
    run_req(1'b0, 32'h5, 64'd0, 2, 0);

    for (int t = 0; t < 300; t++) begin
      ra = (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 7));
      run_req($urandom_range(0, 2) == 0, ra, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    check("rw_enable_overlap", 64'(overlap), 64'd0);
    check("mem_req_stability", 64'(stab_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
